// File: rtl/gray_codec_pipe.sv
// Pipelined Gray-code codec with valid/ready on both sides.
// Each beat carries its own mode: 00 bin2gray, 01 gray2bin, 10 gray increment,
// 11 passthrough. Register levels 0..C_PIPE_STAGES-1 each resolve one chunk of
// the gray2bin prefix-XOR chain (MSB first); the increment and re-encode happen
// in front of the last chunk register. Level C_PIPE_STAGES is the output
// register, so a beat accepted at edge N appears after edge N+C_PIPE_STAGES.
module gray_codec_pipe #(
   parameter int C_DATA_WIDTH  = 8,
   parameter int C_PIPE_STAGES = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [C_DATA_WIDTH-1:0] s_data,
   input  logic [1:0]              s_mode,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [C_DATA_WIDTH-1:0] m_data,
   output logic [1:0]              m_mode,
   output logic                    busy
);

   localparam int W  = C_DATA_WIDTH;
   localparam int S  = C_PIPE_STAGES;
   // bits of the prefix-XOR chain resolved per stage
   localparam int CH = (W + S - 1) / S;

   localparam logic [1:0] MODE_B2G  = 2'b00;
   localparam logic [1:0] MODE_G2B  = 2'b01;
   localparam logic [1:0] MODE_INC  = 2'b10;

   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   logic [S:0]        vld;
   logic [S:0][1:0]   mode_q;
   logic [S:0][W-1:0] data_q;
   logic [S:0][W-1:0] data_d;
   logic              advance;

   // Work done in front of register level k. Bit i of the chain sits at
   // distance W-1-i from the MSB and belongs to chunk (W-1-i)/CH. Level S
   // (the output register) matches no chunk and just copies.
   function automatic logic [W-1:0] stage_fn(input int k, input logic [1:0] mode,
                                             input logic [W-1:0] din);
      logic [W-1:0] r;
      r = din;
      if (mode == MODE_B2G) begin
         if (k == 0) r = din ^ (din >> 1);
      end else if (mode == MODE_G2B || mode == MODE_INC) begin
         for (int i = W - 2; i >= 0; i--) begin
            if ((W - 1 - i) / CH == k) r[i] = r[i+1] ^ r[i];
         end
         if (mode == MODE_INC && k == S - 1) begin
            r = r + ONE;
            r = r ^ (r >> 1);
         end
      end
      return r;
   endfunction

   assign advance = !vld[S] || m_ready;
   assign s_ready = advance && !rst;
   assign m_valid = vld[S];
   assign m_data  = data_q[S];
   assign m_mode  = mode_q[S];
   assign busy    = |vld;

   // Per-level next data: level 0 from the input port, others from the level before.
   always_comb begin
      data_d    = '0;
      data_d[0] = stage_fn(0, s_mode, s_data);
      for (int k = 1; k <= S; k++) begin
         data_d[k] = stage_fn(k, mode_q[k-1], data_q[k-1]);
      end
   end

   // Whole pipe shifts together on advance; bubbles travel like beats.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld    <= '0;
         mode_q <= '0;
         data_q <= '0;
      end else if (advance) begin
         vld[0]    <= s_valid && s_ready;
         mode_q[0] <= s_mode;
         data_q[0] <= data_d[0];
         for (int k = 1; k <= S; k++) begin
            vld[k]    <= vld[k-1];
            mode_q[k] <= mode_q[k-1];
            data_q[k] <= data_d[k];
         end
      end
   end

endmodule

// File: tb/tb_gray_codec_pipe.sv
// Directed bench for gray_codec_pipe: W=8/S=2 and W=4/S=4 directed vectors,
// plus W=10 sweeps of all values in all modes at S = 1, 3, 10.
module tb_gray_codec_pipe;

   logic clk;
   int   n_cmp;
   int   n_err;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, got, want);
      end
   endtask

   // reference model
   function automatic logic [31:0] ref_b2g(input logic [31:0] v);
      return v ^ (v >> 1);
   endfunction

   function automatic logic [31:0] ref_g2b(input logic [31:0] g, input int w);
      logic [31:0] b;
      b = '0;
      b[w-1] = g[w-1];
      for (int i = w - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   function automatic logic [31:0] ref_op(input logic [1:0] m, input logic [31:0] v, input int w);
      logic [31:0] mask;
      mask = (32'd1 << w) - 32'd1;
      case (m)
         2'b00:   return ref_b2g(v) & mask;
         2'b01:   return ref_g2b(v, w);
         2'b10:   return ref_b2g((ref_g2b(v, w) + 32'd1) & mask);
         default: return v;
      endcase
   endfunction

   // ---------------- W=8, S=2 ----------------
   logic       rst8, sv8, sr8, mv8, mr8, busy8;
   logic [7:0] sd8, md8;
   logic [1:0] sm8, mm8;

   gray_codec_pipe #(.C_DATA_WIDTH(8), .C_PIPE_STAGES(2)) u_dut8 (
      .clk(clk), .rst(rst8), .s_valid(sv8), .s_ready(sr8), .s_data(sd8), .s_mode(sm8),
      .m_valid(mv8), .m_ready(mr8), .m_data(md8), .m_mode(mm8), .busy(busy8));

   task automatic drive8(input logic rs, input logic v, input logic [7:0] d,
                         input logic [1:0] m, input logic r);
      @(negedge clk);
      rst8 = rs; sv8 = v; sd8 = d; sm8 = m; mr8 = r;
      #1;
   endtask

   // ---------------- W=4, S=4 ----------------
   logic       rst4, sv4, sr4, mv4, mr4, busy4, done4;
   logic [3:0] sd4, md4;
   logic [1:0] sm4, mm4;

   gray_codec_pipe #(.C_DATA_WIDTH(4), .C_PIPE_STAGES(4)) u_dut4 (
      .clk(clk), .rst(rst4), .s_valid(sv4), .s_ready(sr4), .s_data(sd4), .s_mode(sm4),
      .m_valid(mv4), .m_ready(mr4), .m_data(md4), .m_mode(mm4), .busy(busy4));

   task automatic drive4(input logic rs, input logic v, input logic [3:0] d,
                         input logic [1:0] m, input logic r);
      @(negedge clk);
      rst4 = rs; sv4 = v; sd4 = d; sm4 = m; mr4 = r;
      #1;
   endtask

   // Gray increment wrap at W=4: 0x8 -> 0x0, five edges after acceptance-cycle drive
   initial begin
      done4 = 1'b0;
      rst4 = 1'b1; sv4 = 1'b0; sd4 = '0; sm4 = '0; mr4 = 1'b1;
      drive4(1, 0, 4'h0, 2'b00, 1);
      drive4(0, 1, 4'h8, 2'b10, 1);
      drive4(0, 0, 4'h0, 2'b00, 1);
      drive4(0, 0, 4'h0, 2'b00, 1);
      drive4(0, 0, 4'h0, 2'b00, 1);
      drive4(0, 0, 4'h0, 2'b00, 1);
      check("w4_early_valid", 32'(mv4), 32'd0);
      check("w4_busy", 32'(busy4), 32'd1);
      drive4(0, 0, 4'h0, 2'b00, 1);
      check("w4_valid", 32'(mv4), 32'd1);
      check("w4_inc_wrap", 32'(md4), 32'h0);
      check("w4_mode", 32'(mm4), 32'd2);
      done4 = 1'b1;
   end

   // ---------------- W=10 sweeps ----------------
   for (genvar g = 0; g < 3; g++) begin : g_sweep
      localparam int S = (g == 0) ? 1 : ((g == 1) ? 3 : 10);
      logic       rst_s, sv, sr, mv, mr, bz, done;
      logic [9:0] sd, md;
      logic [1:0] sm, mm;

      gray_codec_pipe #(.C_DATA_WIDTH(10), .C_PIPE_STAGES(S)) u_dut (
         .clk(clk), .rst(rst_s), .s_valid(sv), .s_ready(sr), .s_data(sd), .s_mode(sm),
         .m_valid(mv), .m_ready(mr), .m_data(md), .m_mode(mm), .busy(bz));

      initial begin
         int          in_i;
         int          out_i;
         logic [1:0]  em;
         logic [31:0] ev;
         done = 1'b0;
         rst_s = 1'b1; sv = 1'b0; sd = '0; sm = '0; mr = 1'b0;
         in_i = 0; out_i = 0;
         repeat (2) @(negedge clk);
         rst_s = 1'b0;
         for (int c = 0; c < 20000 && out_i < 4096; c++) begin
            @(negedge clk);
            mr = 1'($urandom_range(0, 1));
            sv = (in_i < 4096);
            sd = 10'(in_i % 1024);
            sm = 2'(in_i / 1024);
            #1;
            if (mv && mr) begin
               em = 2'(out_i / 1024);
               ev = ref_op(em, 32'(out_i % 1024), 10);
               check("sweep", 32'({mm, md}), 32'({em, ev[9:0]}));
               out_i++;
            end
            if (sv && sr) in_i++;
         end
         check("sweep_count", 32'(out_i), 32'd4096);
         done = 1'b1;
      end
   end

   // ---------------- directed sequence on W=8, S=2 ----------------
   initial begin
      int         in_i;
      int         out_i;
      logic       stalled_prev;
      logic [7:0] held;
      logic [15:0] pat;
      n_cmp = 0; n_err = 0;
      rst8 = 1'b1; sv8 = 1'b0; sd8 = '0; sm8 = '0; mr8 = 1'b1;

      // reset state
      drive8(1, 1, 8'hFF, 2'b11, 1);
      check("rst_sready", 32'(sr8), 32'd0);
      check("rst_mvalid", 32'(mv8), 32'd0);
      check("rst_mdata", 32'(md8), 32'd0);
      check("rst_busy", 32'(busy8), 32'd0);
      drive8(0, 0, 8'h00, 2'b00, 0);
      check("idle_sready", 32'(sr8), 32'd1);

      // basic conversions
      drive8(0, 1, 8'hB5, 2'b00, 1);
      drive8(0, 1, 8'hEF, 2'b01, 1);
      drive8(0, 1, 8'h5A, 2'b11, 1);
      check("basic_latency", 32'(mv8), 32'd0);
      drive8(0, 0, 8'h00, 2'b00, 1);
      check("basic_v0", 32'(mv8), 32'd1);
      check("basic_b2g", 32'({mm8, md8}), 32'({2'b00, 8'hEF}));
      drive8(0, 0, 8'h00, 2'b00, 1);
      check("basic_g2b", 32'({mm8, md8}), 32'({2'b01, 8'hB5}));
      drive8(0, 0, 8'h00, 2'b00, 1);
      check("basic_pass", 32'({mm8, md8}), 32'({2'b11, 8'h5A}));
      drive8(0, 0, 8'h00, 2'b00, 1);
      check("basic_drain", 32'(mv8), 32'd0);
      check("basic_busy", 32'(busy8), 32'd0);

      // gray increment and wrap
      drive8(0, 1, 8'hEF, 2'b10, 1);
      drive8(0, 1, 8'h80, 2'b10, 1);
      drive8(0, 0, 8'h00, 2'b00, 1);
      drive8(0, 0, 8'h00, 2'b00, 1);
      check("inc_ef", 32'(md8), 32'hED);
      drive8(0, 0, 8'h00, 2'b00, 1);
      check("inc_wrap_v", 32'(mv8), 32'd1);
      check("inc_wrap", 32'(md8), 32'h00);

      // bubbles 1,0,1
      drive8(0, 0, 8'h00, 2'b00, 1);
      drive8(0, 1, 8'h11, 2'b11, 1);
      drive8(0, 0, 8'h00, 2'b11, 1);
      check("bub_busy1", 32'(busy8), 32'd1);
      drive8(0, 1, 8'h22, 2'b11, 1);
      check("bub_v_e2", 32'(mv8), 32'd0);
      check("bub_busy2", 32'(busy8), 32'd1);
      drive8(0, 0, 8'h00, 2'b00, 1);
      check("bub_v_e3", 32'(mv8), 32'd1);
      check("bub_d1", 32'(md8), 32'h11);
      drive8(0, 0, 8'h00, 2'b00, 1);
      check("bub_v_e4", 32'(mv8), 32'd0);
      check("bub_busy4", 32'(busy8), 32'd1);
      drive8(0, 0, 8'h00, 2'b00, 1);
      check("bub_v_e5", 32'(mv8), 32'd1);
      check("bub_d2", 32'(md8), 32'h22);
      drive8(0, 0, 8'h00, 2'b00, 1);
      check("bub_v_e6", 32'(mv8), 32'd0);
      check("bub_busy6", 32'(busy8), 32'd0);

      // back-pressure: bin2gray of 0..15 under a fixed m_ready pattern
      pat = 16'b1011_0010_1110_0101;
      in_i = 0; out_i = 0; stalled_prev = 1'b0; held = '0;
      for (int c = 0; c < 200 && out_i < 16; c++) begin
         drive8(0, in_i < 16, 8'(in_i), 2'b00, pat[c % 16]);
         if (stalled_prev) check("bp_hold", 32'(md8), 32'(held));
         if (mv8 && !mr8) check("bp_sready", 32'(sr8), 32'd0);
         if (mv8 && mr8) begin
            check("bp_data", 32'(md8), ref_b2g(32'(out_i)));
            out_i++;
         end
         if (sv8 && sr8) in_i++;
         stalled_prev = mv8 && !mr8;
         held = md8;
      end
      check("bp_count", 32'(out_i), 32'd16);
      drive8(0, 0, 8'h00, 2'b00, 1);
      check("bp_no_dup", 32'(mv8), 32'd0);
      check("bp_busy", 32'(busy8), 32'd0);

      // reset mid-operation
      drive8(0, 1, 8'h01, 2'b11, 0);
      drive8(0, 1, 8'h02, 2'b11, 0);
      drive8(0, 1, 8'h03, 2'b11, 0);
      drive8(0, 0, 8'h00, 2'b00, 0);
      check("mid_full_v", 32'(mv8), 32'd1);
      check("mid_stall_sready", 32'(sr8), 32'd0);
      drive8(1, 1, 8'h44, 2'b11, 1);
      check("mid_rst_sready", 32'(sr8), 32'd0);
      drive8(0, 0, 8'h00, 2'b00, 1);
      check("mid_after_v", 32'(mv8), 32'd0);
      check("mid_after_d", 32'(md8), 32'd0);
      check("mid_after_busy", 32'(busy8), 32'd0);
      check("mid_after_sready", 32'(sr8), 32'd1);
      for (int c = 0; c < 5; c++) begin
         drive8(0, 0, 8'h00, 2'b00, 1);
         check("mid_no_old", 32'(mv8), 32'd0);
      end

      // wait for the parallel tests
      for (int c = 0; c < 30000 &&
           !(done4 && g_sweep[0].done && g_sweep[1].done && g_sweep[2].done); c++) begin
         @(negedge clk);
      end
      check("all_done", 32'({done4, g_sweep[0].done, g_sweep[1].done, g_sweep[2].done}), 32'hF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
